// File: rtl/sid_pkg.sv
// sid_pkg: shared definitions for the sid register-write command stream.
// Command word (16 bits):
//   [15]=0 : register write, [12:8]=sid address, [7:0]=data, [14:13] don't care
//   [15]=1 : delay, [14:0]=number of 1MHz CLKen ticks
// Host-side encoders and the bus sequencer both decode through these helpers.
package sid_pkg;

    localparam int CMD_W         = 16;
    localparam int SID_ADDR_W    = 5;
    localparam int SID_DATA_W    = 8;
    localparam int CMD_DELAY_BIT = 15;
    localparam int DELAY_W       = 15;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DELAY = 1'b1
    } seq_state_e;

    function automatic logic cmd_is_delay(input logic [CMD_W-1:0] cmd);
        return cmd[CMD_DELAY_BIT];
    endfunction

    function automatic logic [SID_ADDR_W-1:0] cmd_addr(input logic [CMD_W-1:0] cmd);
        return cmd[SID_DATA_W +: SID_ADDR_W];
    endfunction

    function automatic logic [SID_DATA_W-1:0] cmd_data(input logic [CMD_W-1:0] cmd);
        return cmd[SID_DATA_W-1:0];
    endfunction

    function automatic logic [DELAY_W-1:0] cmd_delay(input logic [CMD_W-1:0] cmd);
        return cmd[DELAY_W-1:0];
    endfunction

endpackage

// File: rtl/sid_cmd_fifo.sv
// sid_cmd_fifo: synchronous DEPTH x CMD_W command FIFO.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   flush_i      - synchronous empty; overrides push/pop in the same cycle
//   push_i       - write wdata_i (ignored while full)
//   wdata_i      - command word in
//   pop_i        - drop head entry (ignored while empty)
//   rdata_o      - head entry (combinational read of the storage array)
//   full_o       - level == DEPTH
//   empty_o      - level == 0
//   level_o      - occupancy 0..DEPTH
module sid_cmd_fifo
    import sid_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [CMD_W-1:0] wdata_i,
    input  logic             pop_i,
    output logic [CMD_W-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i  && !empty_o && !flush_i;

    // Pointers are AW bits wide so they wrap modulo DEPTH on their own;
    // the separate level counter tells full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage has no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sid_bus_sequencer.sv
// sid_bus_sequencer: initiator side of the sid register-write bus.
// Buffers host commands and plays them out at most one per CLKen tick:
// writes pulse WR for one CLK with ADDR/DATA, delays hold off the queue
// for N further ticks.
// Ports:
//   CLK, RSTn   - master clock, async active-low reset
//   CLKen       - 1MHz enable, one CLK wide
//   FLUSH       - synchronous: empty queue, abort delay, drop WR
//   IN_VALID/IN_CMD/IN_READY - host command handshake (IN_READY = !full)
//   WR/ADDR/DATA - sid bus (registered)
//   BUSY        - queue non-empty or a delay in progress
//   LEVEL       - queue occupancy
module sid_bus_sequencer
    import sid_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    CLKen,
    input  logic                    FLUSH,
    input  logic                    IN_VALID,
    input  logic [CMD_W-1:0]        IN_CMD,
    output logic                    IN_READY,
    output logic                    WR,
    output logic [SID_ADDR_W-1:0]   ADDR,
    output logic [SID_DATA_W-1:0]   DATA,
    output logic                    BUSY,
    output logic [$clog2(DEPTH):0]  LEVEL
);

    seq_state_e              state_q;
    logic [DELAY_W-1:0]      cnt_q;
    logic                    wr_q;
    logic [SID_ADDR_W-1:0]   addr_q;
    logic [SID_DATA_W-1:0]   data_q;

    logic [CMD_W-1:0]        head;
    logic                    full, empty;
    logic                    pop;

    // A pop only happens from IDLE on a tick; the FIFO itself also
    // ignores pop under FLUSH, but gating here keeps the FSM consistent.
    assign pop = CLKen && !empty && (state_q == ST_IDLE) && !FLUSH;

    sid_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (CLK),
        .rst_n   (RSTn),
        .flush_i (FLUSH),
        .push_i  (IN_VALID),
        .wdata_i (IN_CMD),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (LEVEL)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (FLUSH) begin
            // ADDR/DATA deliberately keep the last written value.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
        end else begin
            wr_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        if (!cmd_is_delay(head)) begin
                            wr_q   <= 1'b1;
                            addr_q <= cmd_addr(head);
                            data_q <= cmd_data(head);
                        end else if (cmd_delay(head) != '0) begin
                            cnt_q   <= cmd_delay(head);
                            state_q <= ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    // Returning to IDLE on the last tick means the next
                    // pop waits for the following tick.
                    if (CLKen) begin
                        cnt_q <= cnt_q - DELAY_W'(1);
                        if (cnt_q == DELAY_W'(1)) state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign IN_READY = !full;
    assign WR       = wr_q;
    assign ADDR     = addr_q;
    assign DATA     = data_q;
    assign BUSY     = !empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_sid_bus_sequencer.sv
// Directed bench for sid_bus_sequencer. CLKen pulses every 16 CLK while
// ck_run is set; a monitor logs every WR pulse with the tick count.
module tb_sid_bus_sequencer;

    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        CLKen = 1'b0;
    logic        FLUSH = 1'b0;
    logic        IN_VALID = 1'b0;
    logic [15:0] IN_CMD = '0;
    logic        IN_READY;
    logic        WR;
    logic [4:0]  ADDR;
    logic [7:0]  DATA;
    logic        BUSY;
    logic [4:0]  LEVEL;

    sid_bus_sequencer #(.DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .CLKen    (CLKen),
        .FLUSH    (FLUSH),
        .IN_VALID (IN_VALID),
        .IN_CMD   (IN_CMD),
        .IN_READY (IN_READY),
        .WR       (WR),
        .ADDR     (ADDR),
        .DATA     (DATA),
        .BUSY     (BUSY),
        .LEVEL    (LEVEL)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // CLKen generator
    bit ck_run = 1'b1;
    int div = 0;
    always @(negedge CLK) begin
        if (!ck_run) begin
            CLKen = 1'b0;
        end else begin
            div = (div + 1) % 16;
            CLKen = (div == 0);
        end
    end

    // tick counter and last-edge CLKen flag
    int ticks = 0;
    bit ken_last = 1'b0;
    always @(posedge CLK) begin
        ken_last = CLKen;
        if (CLKen) ticks++;
    end

    // WR monitor
    int q_tick[$];
    int q_addr[$];
    int q_data[$];
    int q_lat[$];
    always @(negedge CLK) begin
        if (WR === 1'b1) begin
            q_tick.push_back(ticks);
            q_addr.push_back(int'(ADDR));
            q_data.push_back(int'(DATA));
            q_lat.push_back(int'(ken_last));
        end
    end

    task automatic clr_log();
        q_tick.delete(); q_addr.delete(); q_data.delete(); q_lat.delete();
    endtask

    task automatic push(input logic [15:0] c);
        int n;
        @(negedge CLK);
        IN_CMD = c;
        IN_VALID = 1'b1;
        n = 0;
        while (!IN_READY && n < 500) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 500) chk("push_timeout", 0, 1);
    endtask

    task automatic push_end();
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        @(negedge CLK);
        while ((BUSY || WR) && n < max) begin
            @(negedge CLK);
            n++;
        end
        if (n >= max) chk(tag, 0, 1);
        repeat (3) @(negedge CLK);
    endtask

    function automatic logic [15:0] wcmd(input int k);
        logic [4:0] a;
        logic [7:0] d;
        a = 5'(k);
        d = 8'(k * 9 + 3);
        return {3'b000, a, d};
    endfunction

    int idx;
    bit acc;
    int n;

    initial begin
        // ---- reset state
        repeat (3) @(negedge CLK);
        chk("rst_wr", int'(WR), 0);
        chk("rst_addr", int'(ADDR), 0);
        chk("rst_data", int'(DATA), 0);
        chk("rst_level", int'(LEVEL), 0);
        chk("rst_ready", int'(IN_READY), 1);
        chk("rst_busy", int'(BUSY), 0);
        RSTn = 1'b1;

        // ---- single write
        clr_log();
        push(16'h0418);
        push_end();
        chk("t1_busy_queued", int'(BUSY), 1);
        wait_idle("t1_timeout", 100);
        chk("t1_count", q_tick.size(), 1);
        if (q_tick.size() == 1) begin
            chk("t1_addr", q_addr[0], 'h04);
            chk("t1_data", q_data[0], 'h18);
            chk("t1_latency", q_lat[0], 1);
        end
        chk("t1_busy_after", int'(BUSY), 0);
        chk("t1_wr_after", int'(WR), 0);

        // ---- three back-to-back writes on consecutive ticks
        clr_log();
        push(16'h0011); push(16'h0122); push(16'h0233);
        push_end();
        wait_idle("t2_timeout", 200);
        chk("t2_count", q_tick.size(), 3);
        if (q_tick.size() == 3) begin
            chk("t2_addr0", q_addr[0], 'h00); chk("t2_data0", q_data[0], 'h11);
            chk("t2_addr1", q_addr[1], 'h01); chk("t2_data1", q_data[1], 'h22);
            chk("t2_addr2", q_addr[2], 'h02); chk("t2_data2", q_data[2], 'h33);
            chk("t2_gap01", q_tick[1] - q_tick[0], 1);
            chk("t2_gap12", q_tick[2] - q_tick[1], 1);
        end

        // ---- delay 3: B lands on the 5th tick after A (4 ticks in between)
        clr_log();
        push(16'h0155); push(16'h8003); push(16'h0266);
        push_end();
        wait_idle("t3_timeout", 300);
        chk("t3_count", q_tick.size(), 2);
        if (q_tick.size() == 2) begin
            chk("t3_gap", q_tick[1] - q_tick[0], 5);
            chk("t3_dataB", q_data[1], 'h66);
        end

        // ---- delay 0 consumes just its own tick
        clr_log();
        push(16'h0301); push(16'h8000); push(16'h0402);
        push_end();
        wait_idle("t3b_timeout", 300);
        chk("t3b_count", q_tick.size(), 2);
        if (q_tick.size() == 2) chk("t3b_gap", q_tick[1] - q_tick[0], 2);

        // ---- fill with CLKen stopped, then drain
        clr_log();
        ck_run = 1'b0;
        idx = 0;
        acc = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (acc) idx++;
            IN_VALID = (idx < DEPTH + 2);
            IN_CMD = wcmd(idx);
            acc = IN_VALID && IN_READY;
        end
        chk("t4_accepted", idx, DEPTH);
        chk("t4_level_full", int'(LEVEL), DEPTH);
        chk("t4_ready_low", int'(IN_READY), 0);
        chk("t4_no_wr", q_tick.size(), 0);
        ck_run = 1'b1;
        n = 0;
        while (idx < DEPTH + 2 && n < 2000) begin
            @(negedge CLK);
            n++;
            if (acc) idx++;
            IN_VALID = (idx < DEPTH + 2);
            IN_CMD = wcmd(idx);
            acc = IN_VALID && IN_READY;
        end
        IN_VALID = 1'b0;
        if (n >= 2000) chk("t4_fill_timeout", 0, 1);
        wait_idle("t4_timeout", 1000);
        chk("t4_count", q_tick.size(), DEPTH + 2);
        for (int k = 0; k < q_tick.size() && k < DEPTH + 2; k++) begin
            chk($sformatf("t4_addr%0d", k), q_addr[k], k % 32);
            chk($sformatf("t4_data%0d", k), q_data[k], (k * 9 + 3) % 256);
        end

        // ---- flush during a long delay with writes queued
        push(16'h80FF);
        for (int k = 0; k < 5; k++) push(16'h0A00 | 16'(k));
        push_end();
        n = 0;
        while (!(LEVEL == 5'd5 && BUSY) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) chk("t5_wait_timeout", 0, 1);
        clr_log();
        @(negedge CLK);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        chk("t5_level", int'(LEVEL), 0);
        chk("t5_busy", int'(BUSY), 0);
        chk("t5_ready", int'(IN_READY), 1);
        repeat (100) @(negedge CLK);
        chk("t5_no_wr", q_tick.size(), 0);

        // ---- async reset during a WR cycle
        push(16'h0C77);
        push_end();
        n = 0;
        while (WR !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("t6_saw_wr", int'(WR), 1);
        #2 RSTn = 1'b0;
        #1;
        chk("t6_wr_async", int'(WR), 0);
        chk("t6_addr_rst", int'(ADDR), 0);
        chk("t6_level_rst", int'(LEVEL), 0);
        @(negedge CLK);
        RSTn = 1'b1;
        clr_log();
        push(16'h1F5A);
        push_end();
        wait_idle("t6_timeout", 100);
        chk("t6_count", q_tick.size(), 1);
        if (q_tick.size() == 1) begin
            chk("t6_addr", q_addr[0], 'h1F);
            chk("t6_data", q_data[0], 'h5A);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
